// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, register-file write port and queued UART-event strobe.
// Latency: MEM inputs captured at edge N drive rf_* in cycle N+1; stall holds the entry and it writes only once.
module mem_wb_stage #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_reg_wr,
    input  logic [4:0]  mem_dst,
    input  logic [1:0]  mem_wb_sel,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc4,
    input  logic        uart_evt,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        rf_uart,
    output logic        fwd_valid,
    output logic        uart_pend,
    output logic        uart_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [4:0]        dst_q, dst_d;
    logic [31:0]       data_q, data_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       wb_data;
    logic              pend_nz;
    logic              uart_dec;
    logic              uart_inc;
    logic              uart_drop;

    always_comb begin
        wb_data = mem_alu_out;
        case (mem_wb_sel)
            2'b01:   wb_data = mem_rdata;
            2'b10:   wb_data = mem_pc4;
            default: wb_data = mem_alu_out;
        endcase
    end

    // Outputs depend only on local flops, never on the MEM-side inputs.
    always_comb begin
        pend_nz   = (pend_q != '0);
        rf_wr     = valid_q & ~done_q;
        rf_addr   = dst_q;
        rf_wdata  = data_q;
        rf_uart   = pend_nz & ~rf_wr;
        fwd_valid = valid_q;
        uart_pend = pend_nz;
        uart_ovf  = ovf_q;
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dst_d   = dst_q;
        data_d  = data_q;
        // Flush wins over stall: a flushed slot becomes a bubble even when held.
        if (flush || !stall) begin
            valid_d = mem_reg_wr & (mem_dst != 5'd0) & ~flush;
            dst_d   = mem_dst;
            data_d  = wb_data;
            done_d  = 1'b0;
        end else begin
            done_d  = done_q | rf_wr;
        end
    end

    // A release frees a slot, so an event arriving alongside it is never dropped.
    always_comb begin
        uart_dec  = rf_uart;
        uart_drop = uart_evt & (pend_q == PEND_MAX) & ~uart_dec;
        uart_inc  = uart_evt & ~uart_drop;
        pend_d    = pend_q + PEND_W'(uart_inc) - PEND_W'(uart_dec);
        ovf_d     = ovf_q | uart_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            dst_q   <= 5'd0;
            data_q  <= 32'd0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table followed by randomized traffic against a reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, mem_reg_wr, uart_evt;
    logic [4:0]  mem_dst;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_out, mem_rdata, mem_pc4;
    logic        rf_wr, rf_uart, fwd_valid, uart_pend, uart_ovf;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    mem_wb_stage #(.PEND_W(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_reg_wr(mem_reg_wr), .mem_dst(mem_dst), .mem_wb_sel(mem_wb_sel),
        .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
        .uart_evt(uart_evt),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_uart(rf_uart),
        .fwd_valid(fwd_valid), .uart_pend(uart_pend), .uart_ovf(uart_ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, stl, fl, wr;
        logic [4:0]  dst;
        logic [1:0]  sel;
        logic [31:0] alu, rd, pc;
        logic        evt;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_uart, e_fwd, e_pend, e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic fl, input logic wr,
        input logic [4:0] dst, input logic [1:0] sel,
        input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc, input logic evt,
        input logic e_wr, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic e_uart, input logic e_fwd, input logic e_pend, input logic e_ovf);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.wr = wr; v.dst = dst; v.sel = sel;
        v.alu = alu; v.rd = rd; v.pc = pc; v.evt = evt;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        v.e_uart = e_uart; v.e_fwd = e_fwd; v.e_pend = e_pend; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic stl, input logic fl, input logic wr,
                         input logic [4:0] dst, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc,
                         input logic evt);
        reset = rst; stall = stl; flush = fl; mem_reg_wr = wr; mem_dst = dst;
        mem_wb_sel = sel; mem_alu_out = alu; mem_rdata = rd; mem_pc4 = pc; uart_evt = evt;
    endtask

    // Reference model state: one pipeline slot plus an integer event queue depth.
    logic        m_valid, m_written, m_ovf;
    logic [4:0]  m_dst;
    logic [31:0] m_data;
    int          m_pend;
    localparam int CAP = 3;

    function automatic logic m_wr();
        return m_valid && !m_written;
    endfunction

    function automatic logic m_uart();
        return (m_pend > 0) && !m_wr();
    endfunction

    task automatic model_edge();
        logic wr_now, uart_now;
        wr_now   = m_wr();
        uart_now = m_uart();
        if (reset) begin
            m_valid = 0; m_written = 0; m_dst = 0; m_data = 0; m_pend = 0; m_ovf = 0;
        end else begin
            if (flush || !stall) begin
                m_valid   = mem_reg_wr && (mem_dst != 0) && !flush;
                m_dst     = mem_dst;
                m_data    = (mem_wb_sel == 2'b01) ? mem_rdata :
                            (mem_wb_sel == 2'b10) ? mem_pc4 : mem_alu_out;
                m_written = 0;
            end else if (wr_now) begin
                m_written = 1;
            end
            if (uart_now) m_pend = m_pend - 1;
            if (uart_evt) begin
                if (m_pend < CAP) m_pend = m_pend + 1;
                else m_ovf = 1;
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            rst stl fl wr dst sel alu            rd             pc            evt | wr addr data          uart fwd pend ovf
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  8, 1, 32'h1111,      32'hDEADBEEF,  32'h2222,     0,  1,  8, 32'hDEADBEEF, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3, 2, 32'h1111,      32'h3333,      32'h00400010, 0,  1,  3, 32'h00400010, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 31, 0, 32'hCAFE0001,  32'h3333,      32'h4444,     0,  1, 31, 32'hCAFE0001, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  4, 3, 32'h12345678,  32'h3333,      32'h4444,     0,  1,  4, 32'h12345678, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 32'h5,         0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  9, 0, 32'h99,        0,             0,            0,  1,  9, 32'h99,       0, 1, 0, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 0, 1, 5, 0, 32'h55,     0,             0,            0,  0,  0, 0,            0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1,  5, 0, 32'h55,        0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  5, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 10, 0, 32'hA0,        0,             0,            1,  1, 10, 32'hA0,       0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 11, 0, 32'hB0,        0,             0,            0,  1, 11, 32'hB0,       0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 12, 0, 32'hC0,        0,             0,            0,  1, 12, 32'hC0,       0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 32'h1,         0,             0,            1,  1,  1, 32'h1,        0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2, 0, 32'h2,         0,             0,            1,  1,  2, 32'h2,        0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3, 0, 32'h3,         0,             0,            1,  1,  3, 32'h3,        0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  4, 0, 32'h4,         0,             0,            1,  1,  4, 32'h4,        0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            1,  0,  0, 0,            1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,  6, 0, 32'h66,        0,             0,            1,  1,  6, 32'h66,       0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  7, 0, 32'h77,        0,             0,            1,  1,  7, 32'h77,       0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1,  7, 0, 32'h77,        0,             0,            1,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,             0,             0,            0,  0,  0, 0,            0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].wr, tbl[i].dst, tbl[i].sel,
                  tbl[i].alu, tbl[i].rd, tbl[i].pc, tbl[i].evt);
            @(posedge clk);
            #1;
            check($sformatf("row%0d rf_wr", i),     32'(rf_wr),     32'(tbl[i].e_wr));
            check($sformatf("row%0d rf_uart", i),   32'(rf_uart),   32'(tbl[i].e_uart));
            check($sformatf("row%0d fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].e_fwd));
            check($sformatf("row%0d uart_pend", i), 32'(uart_pend), 32'(tbl[i].e_pend));
            check($sformatf("row%0d uart_ovf", i),  32'(uart_ovf),  32'(tbl[i].e_ovf));
            if (tbl[i].e_wr) begin
                check($sformatf("row%0d rf_addr", i),  32'(rf_addr), 32'(tbl[i].e_addr));
                check($sformatf("row%0d rf_wdata", i), rf_wdata,     tbl[i].e_data);
            end
        end

        m_valid = 0; m_written = 0; m_dst = 0; m_data = 0; m_pend = 0; m_ovf = 0;
        for (int c = 0; c < 3000; c++) begin
            drive((c == 0) || ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6,
                  5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
                  2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) < 3);
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d rf_wr", c),     32'(rf_wr),     32'(m_wr()));
            check($sformatf("rnd%0d rf_uart", c),   32'(rf_uart),   32'(m_uart()));
            check($sformatf("rnd%0d fwd_valid", c), 32'(fwd_valid), 32'(m_valid));
            check($sformatf("rnd%0d uart_pend", c), 32'(uart_pend), 32'(m_pend > 0));
            check($sformatf("rnd%0d uart_ovf", c),  32'(uart_ovf),  32'(m_ovf));
            if (m_wr()) begin
                check($sformatf("rnd%0d rf_addr", c),  32'(rf_addr), 32'(m_dst));
                check($sformatf("rnd%0d rf_wdata", c), rf_wdata,     m_data);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
